// File: rtl/ext_io_bridge.sv
// ext_io_bridge: bridges asynchronous switches and a bouncy push button into
// a core register-file input slot, and forwards changes of a register-file
// output slot to an external ready/valid sink.
//
// Ports:
//   clk_i, rst_ni   : single clock, asynchronous active-low reset
//   ext_in_i        : asynchronous external input word (switches)
//   ext_stb_i       : asynchronous, bouncy capture strobe (push button)
//   core_data_o     : last captured input word (register-file input slot)
//   core_data_i     : register-file output slot, sampled every cycle
//   ext_out_o       : word offered to the external sink
//   ext_valid_o     : ext_out_o holds an offered word
//   ext_ready_i     : sink accepts the word when high together with ext_valid_o
//
// Build option: define EXT_IO_DEBOUNCE_EN to debounce the strobe over
// DEB_CYCLES clocks; otherwise a capture fires on each synchronized rising edge.
module ext_io_bridge #(
  parameter int unsigned N          = 8,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] ext_in_i,
  input  logic         ext_stb_i,
  output logic [N-1:0] core_data_o,
  input  logic [N-1:0] core_data_i,
  output logic [N-1:0] ext_out_o,
  output logic         ext_valid_o,
  input  logic         ext_ready_i
);

  // Elaboration-time guard on the debounce length.
  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("ext_io_bridge: DEB_CYCLES out of range 1..255");
  end

  // Two-flop synchronizers for every asynchronous input.
  logic [N-1:0] in_meta, in_sync;
  logic         stb_meta, stb_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_meta  <= '0;
      in_sync  <= '0;
      stb_meta <= 1'b0;
      stb_sync <= 1'b0;
    end else begin
      in_meta  <= ext_in_i;
      in_sync  <= in_meta;
      stb_meta <= ext_stb_i;
      stb_sync <= stb_meta;
    end
  end

  logic capture_c;

`ifdef EXT_IO_DEBOUNCE_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {CAP_IDLE, CAP_COUNT_HI, CAP_HELD, CAP_COUNT_LO} cap_state_e;

  cap_state_e       cap_state, cap_state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Capture FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_state <= CAP_IDLE;
      cnt       <= '0;
    end else begin
      cap_state <= cap_state_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // The sample that leaves IDLE/HELD counts as the first of DEB_CYCLES samples.
  always_comb begin
    cap_state_nxt = cap_state;
    cnt_nxt       = cnt;
    capture_c     = 1'b0;
    case (cap_state)
      CAP_IDLE: begin
        if (stb_sync) begin
          if (CNT_LAST == '0) begin
            capture_c     = 1'b1;
            cap_state_nxt = CAP_HELD;
          end else begin
            cap_state_nxt = CAP_COUNT_HI;
            cnt_nxt       = CNT_W'(1);
          end
        end
      end
      CAP_COUNT_HI: begin
        if (!stb_sync) begin
          cap_state_nxt = CAP_IDLE;
          cnt_nxt       = '0;
        end else if (cnt == CNT_LAST) begin
          capture_c     = 1'b1;
          cap_state_nxt = CAP_HELD;
          cnt_nxt       = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      CAP_HELD: begin
        if (!stb_sync) begin
          if (CNT_LAST == '0) begin
            cap_state_nxt = CAP_IDLE;
          end else begin
            cap_state_nxt = CAP_COUNT_LO;
            cnt_nxt       = CNT_W'(1);
          end
        end
      end
      CAP_COUNT_LO: begin
        if (stb_sync) begin
          cap_state_nxt = CAP_HELD;
          cnt_nxt       = '0;
        end else if (cnt == CNT_LAST) begin
          cap_state_nxt = CAP_IDLE;
          cnt_nxt       = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end
`else
  logic stb_prev;

  // Rising-edge detect on the synchronized strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stb_prev <= 1'b0;
    else         stb_prev <= stb_sync;
  end

  assign capture_c = stb_sync & ~stb_prev;
`endif

  // Captured word holds between captures.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        core_data_o <= '0;
    else if (capture_c) core_data_o <= in_sync;
  end

  typedef enum logic {OUT_IDLE, OUT_SEND} out_state_e;

  out_state_e   out_state, out_state_nxt;
  logic [N-1:0] last_sent, last_sent_nxt, ext_out_nxt;
  logic         valid_nxt;

  // Output FSM state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_state   <= OUT_IDLE;
      last_sent   <= '0;
      ext_out_o   <= '0;
      ext_valid_o <= 1'b0;
    end else begin
      out_state   <= out_state_nxt;
      last_sent   <= last_sent_nxt;
      ext_out_o   <= ext_out_nxt;
      ext_valid_o <= valid_nxt;
    end
  end

  // Changes to core_data_i are ignored during SEND and re-compared in IDLE.
  always_comb begin
    out_state_nxt = out_state;
    last_sent_nxt = last_sent;
    ext_out_nxt   = ext_out_o;
    valid_nxt     = ext_valid_o;
    case (out_state)
      OUT_IDLE: begin
        if (core_data_i != last_sent) begin
          ext_out_nxt   = core_data_i;
          last_sent_nxt = core_data_i;
          valid_nxt     = 1'b1;
          out_state_nxt = OUT_SEND;
        end
      end
      OUT_SEND: begin
        if (ext_ready_i) begin
          valid_nxt     = 1'b0;
          out_state_nxt = OUT_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ext_io_bridge.sv
module tb_ext_io_bridge;

  localparam int unsigned N   = 8;
  localparam int unsigned DEB = 4;
`ifdef EXT_IO_DEBOUNCE_EN
  localparam int unsigned LAT = 2 + DEB;
`else
  localparam int unsigned LAT = 3;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [N-1:0] ext_in_i;
  logic         ext_stb_i;
  logic [N-1:0] core_data_o;
  logic [N-1:0] core_data_i;
  logic [N-1:0] ext_out_o;
  logic         ext_valid_o;
  logic         ext_ready_i;

  ext_io_bridge #(.N(N), .DEB_CYCLES(DEB)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ext_in_i    (ext_in_i),
    .ext_stb_i   (ext_stb_i),
    .core_data_o (core_data_o),
    .core_data_i (core_data_i),
    .ext_out_o   (ext_out_o),
    .ext_valid_o (ext_valid_o),
    .ext_ready_i (ext_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] sb_q[$];

  typedef struct {
    logic [N-1:0] data;
    int           wait_n;
    bit           send;
  } out_vec_t;

  out_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected word.
  always @(negedge clk_i) begin
    if (rst_ni && ext_valid_o && ext_ready_i) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %0h expected none", ext_out_o);
      end else begin
        logic [N-1:0] e;
        e = sb_q.pop_front();
        if (ext_out_o !== e) begin
          bad++;
          $display("FAIL sb_word: got %0h expected %0h", ext_out_o, e);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] prev;
    logic [7:0]   pat;

    vecs[0] = '{data: 8'h81, wait_n: 5, send: 1'b1};
    vecs[1] = '{data: 8'h81, wait_n: 0, send: 1'b0};
    vecs[2] = '{data: 8'h00, wait_n: 0, send: 1'b1};
    vecs[3] = '{data: 8'h5A, wait_n: 2, send: 1'b1};
    vecs[4] = '{data: 8'h5A, wait_n: 0, send: 1'b0};

    rst_ni = 1'b0; ext_in_i = '0; ext_stb_i = 1'b0; core_data_i = '0; ext_ready_i = 1'b0;
    #1;
    check("rst_core_data", 32'(core_data_o), 32'h0);
    check("rst_ext_out",   32'(ext_out_o),   32'h0);
    check("rst_valid",     32'(ext_valid_o), 32'h0);
    tick(); tick();
    rst_ni = 1'b1;

    // Stable press: visible exactly after edge LAT, never before.
    ext_in_i = 8'h5A; ext_stb_i = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      check("cap_latency", 32'(core_data_o), (e >= int'(LAT)) ? 32'h5A : 32'h0);
    end
    ext_in_i = 8'hFF;
    for (int e = 0; e < 4; e++) tick();
    check("cap_once_per_press", 32'(core_data_o), 32'h5A);
    ext_stb_i = 1'b0;
    for (int e = 0; e < 24; e++) tick();

    // Single-cycle strobe pulse.
    ext_in_i = 8'hA5; ext_stb_i = 1'b1;
    tick();
    ext_stb_i = 1'b0;
    check("pulse_e1", 32'(core_data_o), 32'h5A);
    for (int e = 2; e <= 4; e++) begin
      tick();
`ifdef EXT_IO_DEBOUNCE_EN
      check("pulse_filtered", 32'(core_data_o), 32'h5A);
`else
      check("pulse_capture", 32'(core_data_o), (e >= 3) ? 32'hA5 : 32'h5A);
`endif
    end
    for (int e = 0; e < 24; e++) tick();

`ifdef EXT_IO_DEBOUNCE_EN
    // Bouncing press 1-1-0-0-1-1-0-0 then stable: one capture at edge 14.
    prev = core_data_o;
    pat  = 8'b0011_0011;
    ext_in_i = 8'h3C;
    for (int e = 1; e <= 14; e++) begin
      ext_stb_i = (e <= 8) ? pat[e-1] : 1'b1;
      tick();
      check("bounce_capture", 32'(core_data_o), (e >= 14) ? 32'h3C : 32'(prev));
    end
    ext_in_i = 8'h77;
    for (int e = 0; e < 6; e++) tick();
    check("bounce_single", 32'(core_data_o), 32'h3C);
    ext_stb_i = 1'b0;
    for (int e = 0; e < 24; e++) tick();
`endif

    // Output path: no offer while core_data_i matches last_sent after reset.
    for (int e = 0; e < 3; e++) begin
      tick();
      check("out_idle_after_rst", 32'(ext_valid_o), 32'h0);
    end

    for (int i = 0; i < 5; i++) begin
      core_data_i = vecs[i].data;
      if (vecs[i].send) sb_q.push_back(vecs[i].data);
      tick();
      check("vec_valid", 32'(ext_valid_o), 32'(vecs[i].send));
      if (vecs[i].send) begin
        check("vec_word", 32'(ext_out_o), 32'(vecs[i].data));
        for (int w = 0; w < vecs[i].wait_n; w++) begin
          tick();
          check("vec_hold_valid", 32'(ext_valid_o), 32'h1);
          check("vec_hold_word",  32'(ext_out_o),   32'(vecs[i].data));
        end
        ext_ready_i = 1'b1;
        tick();
        ext_ready_i = 1'b0;
        check("vec_drop", 32'(ext_valid_o), 32'h0);
      end else begin
        for (int w = 0; w < 3; w++) begin
          tick();
          check("vec_no_resend", 32'(ext_valid_o), 32'h0);
        end
      end
    end

    // Changes during SEND: intermediate 8'h22 is skipped, 8'h33 follows back-to-back.
    core_data_i = 8'h11; sb_q.push_back(8'h11);
    tick();
    check("seq_valid_11", 32'(ext_valid_o), 32'h1);
    core_data_i = 8'h22;
    tick();
    core_data_i = 8'h33;
    tick();
    check("seq_hold_11", 32'(ext_out_o), 32'h11);
    sb_q.push_back(8'h33);
    ext_ready_i = 1'b1;
    tick();
    check("seq_gap", 32'(ext_valid_o), 32'h0);
    tick();
    check("seq_valid_33", 32'(ext_valid_o), 32'h1);
    check("seq_word_33",  32'(ext_out_o),   32'h33);
    tick();
    ext_ready_i = 1'b0;
    check("seq_done", 32'(ext_valid_o), 32'h0);

    // Reset mid-SEND and mid-debounce.
    core_data_i = 8'hC3;
    tick();
    check("mid_send_valid", 32'(ext_valid_o), 32'h1);
    ext_in_i = 8'h99; ext_stb_i = 1'b1;
    tick(); tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_core", 32'(core_data_o), 32'h0);
    check("async_rst_out",  32'(ext_out_o),   32'h0);
    check("async_rst_valid", 32'(ext_valid_o), 32'h0);
    core_data_i = '0; ext_stb_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      check("post_rst_valid", 32'(ext_valid_o), 32'h0);
      check("post_rst_core",  32'(core_data_o), 32'h0);
    end

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
